// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Request/acknowledge bus between the Memory-stage access controller and a
// variable-latency data memory.
//   mem_req   : request valid, raised by the controller
//   mem_we    : 1 = write, 0 = read; meaningful while mem_req=1
//   mem_addr  : word-aligned byte address of the access
//   mem_wdata : store data
//   mem_ack   : single-cycle completion pulse from the memory
//   mem_rdata : read data, valid alongside mem_ack on a read
interface mem_stage_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// Sequences data-memory accesses for the M stage of the 5-stage MIPS
// pipeline. Each load/store is latched, presented on the memory bus until
// acknowledged, then released for one DONE cycle so the pipeline advances.
// A misaligned address or a memory that never answers locks the block in
// a sticky error state until reset.
// Ports:
//   clk, reset             : clock and synchronous active-high reset
//   MemWriteM, MemtoRegM   : M-stage store / load flags
//   ALUOutM, WriteDataM    : byte address and store data of the access
//   mem                    : memory bus (master side)
//   ReadDataW              : data of the last completed load
//   StallM                 : hold F/D, D/E, E/M; bubble into M/W
//   err, err_addr          : sticky error flag and offending address
module mem_stage_ctrl #(
  parameter int LAT_MAX = 15,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemWriteM,
  input  logic                  MemtoRegM,
  input  logic [31:0]           ALUOutM,
  input  logic [31:0]           WriteDataM,
  mem_stage_ctrl_if.master      mem,
  output logic [31:0]           ReadDataW,
  output logic                  StallM,
  output logic                  err,
  output logic [31:0]           err_addr
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  state_t         state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]    addr_q, wdata_q, rdata_q, err_addr_q;
  logic           we_q, err_q;

  logic           acc, aligned, timeout;
  logic           latch, capture, set_err, req, stall;
  logic [31:0]    err_src;

  assign acc     = MemWriteM | MemtoRegM;
  assign aligned = (ALUOutM[1:0] == 2'b00);
  // Last allowed REQ cycle: counter starts at 0 on the first one.
  assign timeout = (cnt == CNT_W'(LAT_MAX - 1));

  // Next-state and per-cycle control. An ack in the final REQ cycle takes
  // priority over the timeout. DONE always returns to IDLE because the
  // instruction still sitting in M is the one that just completed.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    latch   = 1'b0;
    capture = 1'b0;
    set_err = 1'b0;
    err_src = ALUOutM;
    req     = 1'b0;
    stall   = 1'b0;
    case (state)
      IDLE: begin
        if (acc) begin
          stall = 1'b1;
          if (aligned) begin
            latch   = 1'b1;
            cnt_n   = '0;
            state_n = REQ;
          end else begin
            set_err = 1'b1;
            err_src = ALUOutM;
            state_n = ERR;
          end
        end
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (mem.mem_ack) begin
          capture = ~we_q;
          state_n = DONE;
        end else if (timeout) begin
          set_err = 1'b1;
          err_src = addr_q;
          state_n = ERR;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      ERR: begin
        stall = 1'b1;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers. A store takes priority when both flags
  // are set, so ReadDataW only moves on a completed read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (latch) begin
        addr_q  <= {ALUOutM[31:2], 2'b00};
        wdata_q <= WriteDataM;
        we_q    <= MemWriteM;
      end
      if (capture) begin
        rdata_q <= mem.mem_rdata;
      end
      if (set_err) begin
        err_q      <= 1'b1;
        err_addr_q <= err_src;
      end
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign ReadDataW     = rdata_q;
  assign StallM        = stall;
  assign err           = err_q;
  assign err_addr      = err_addr_q;

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Sequences data-memory accesses issued by the Memory stage of the 5-stage MIPS pipeline. It drives a request/acknowledge interface to a variable-latency data memory and stalls the pipeline registers upstream of and including E->M while an access is outstanding. It returns load data toward Writeback. Misaligned accesses and memory timeouts halt the pipeline through a sticky error.

Parameters:
LAT_MAX, 15, maximum REQ-state cycles waited for mem_ack before timeout (1..2^CNT_W-1)
CNT_W, 4, width of the wait counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
MemWriteM  in  1  M-stage instruction is a store
MemtoRegM  in  1  M-stage instruction is a load
ALUOutM  in  32  byte address of the access
WriteDataM  in  32  store data
mem_req  out  1  memory request valid
mem_we  out  1  1 = write, 0 = read; valid when mem_req=1
mem_addr  out  32  latched word address (byte address, bits[1:0]=0)
mem_wdata  out  32  latched store data
mem_ack  in  1  memory completion, single-cycle pulse
mem_rdata  in  32  read data, valid when mem_ack=1 on a read
ReadDataW  out  32  last completed load data, registered
StallM  out  1  hold the F/D, D/E and E/M pipeline registers; bubble into M/W
err  out  1  sticky error
err_addr  out  32  address that caused the error

Behaviour:
- Reset: reset is synchronous, active-high, on clk. After any edge with reset=1: state=IDLE, counter=0, and mem_req, mem_we, mem_addr, mem_wdata, ReadDataW, err and err_addr all 0. StallM is 0 while in IDLE with no access.
- acc = MemWriteM | MemtoRegM. is_wr = MemWriteM. When both inputs are 1 the access is a write, and ReadDataW is not updated.
- StallM is combinational: 1 when (IDLE & acc), in REQ, or in ERR. It is 0 in DONE.
- IDLE:
  - acc & ALUOutM[1:0]==0: latch mem_addr, mem_wdata and mem_we; counter=0; go to REQ.
  - acc & ALUOutM[1:0]!=0: err=1, err_addr=ALUOutM; go to ERR.
  - Otherwise stay in IDLE.
- REQ:
  - mem_req=1 with the latched fields held stable.
  - mem_ack=1: on a read, ReadDataW<=mem_rdata. Go to DONE.
  - mem_ack=0 and counter==LAT_MAX-1: err=1, err_addr=mem_addr; go to ERR.
  - Otherwise counter+1.
  - When ack and the timeout condition coincide, ack wins.
- DONE:
  - mem_req=0 and StallM=0, so the pipeline advances at this edge.
  - Always go to IDLE, even when acc=1, because the instruction in M is still the completed one during this cycle.
- ERR: mem_req=0 and StallM=1. Held until reset.
- mem_req drops in the cycle after the one in which mem_ack is seen.
- mem_ack in IDLE, DONE or ERR is ignored.
- Latency: an access present in M at cycle t puts mem_req=1 in cycles t+1..t+k, where mem_ack arrives at t+k. DONE is at t+k+1 and the pipeline advances at the end of it. Stall cycles = k+1, minimum 2 (k=1).
- Back-to-back memory instructions: each one passes through IDLE -> REQ -> DONE with no overlap.
- Reset in REQ: mem_req=0 from the next cycle, and a later mem_ack is ignored.
- ReadDataW holds its value across stores and non-memory instructions.

Test Plan:
1. Load: MemtoRegM=1, ALUOutM=0x100; memory acks 3 cycles after the req rises with rdata=0xDEADBEEF. Required: mem_req high 3 cycles, mem_we=0, mem_addr=0x100, StallM high 4 cycles, ReadDataW=0xDEADBEEF from the DONE cycle onward.
2. Store: MemWriteM=1, ALUOutM=0x204, WriteDataM=0x12345678; ack after 1 cycle. Required: mem_we=1, mem_wdata=0x12345678, StallM high 2 cycles, ReadDataW unchanged.
3. Misaligned: MemtoRegM=1, ALUOutM=0x103. Required: no mem_req; err=1 and err_addr=0x103 the next cycle; StallM stays 1; a reset pulse clears everything.
4. Timeout: read to 0x40 with mem_ack never asserted. Required: mem_req high exactly 15 cycles, then err=1, err_addr=0x40, mem_req=0. Repeat with ack in the 15th cycle: no error.
5. Back-to-back: a load then a store in consecutive M-stage slots, ack latency 1 each. Required: two distinct request phases separated by a DONE cycle with StallM=0, and correct addresses for each.
6. Reset mid-REQ, plus spurious ack: assert reset during cycle 2 of REQ. Required: mem_req=0 next cycle and outputs at reset values. A later mem_ack while in IDLE causes no change to ReadDataW.
